// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: diff = a - b, LSB first, one bit per clock, single registered borrow.
// Latency: N edges from accept to o_valid; minimum accept-to-accept spacing N+2 edges.
// Backpressure: result held stable in DONE until o_ready; no new operands accepted until taken.
module serial_subtractor #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         i_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         o_valid,
  input  logic         o_ready,
  output logic [N-1:0] diff,
  output logic         borrow,
  output logic         overflow,
  output logic         zero
);

  localparam int             CW   = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0]  LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [N-1:0]  a_sr;
  logic [N-1:0]  b_sr;
  logic [N-1:0]  res_sr;
  logic          br;
  logic [CW-1:0] cnt;

  // One-bit full-subtractor slice working on the operand LSBs
  logic          a_k;
  logic          b_k;
  logic          d_k;
  logic          br_nxt;
  logic [N-1:0]  res_nxt;

  assign a_k     = a_sr[0];
  assign b_k     = b_sr[0];
  assign d_k     = a_k ^ b_k ^ br;
  assign br_nxt  = (~a_k & b_k) | (~(a_k ^ b_k) & br);
  // The new difference bit enters at the MSB so bit 0 lands at position 0 after N shifts
  assign res_nxt = {d_k, res_sr[N-1:1]};

  // Control FSM, shift datapath and registered result outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      i_ready  <= 1'b0;
      o_valid  <= 1'b0;
      diff     <= '0;
      borrow   <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      br       <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          // i_ready is registered, so it comes up one edge after reset release
          if (i_ready && i_valid) begin
            a_sr    <= a;
            b_sr    <= b;
            res_sr  <= '0;
            br      <= 1'b0;
            cnt     <= '0;
            i_ready <= 1'b0;
            state   <= RUN;
          end else begin
            i_ready <= 1'b1;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= res_nxt;
          br     <= br_nxt;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            // Here a_k/b_k are the operand sign bits and d_k is the result sign bit
            state    <= DONE;
            o_valid  <= 1'b1;
            diff     <= res_nxt;
            borrow   <= br_nxt;
            overflow <= (a_k ^ b_k) & (d_k ^ a_k);
            zero     <= (res_nxt == '0);
          end
        end
        DONE: begin
          if (o_ready) begin
            o_valid <= 1'b0;
            i_ready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          i_ready <= 1'b0;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: N=8 instance under directed and random traffic,
// N=32 instance under directed cases. A cycle-level model tracks accept, N-edge latency and
// result hand-off; expected results come from plain modular arithmetic.
module tb_serial_subtractor;

  localparam int N8  = 8;
  localparam int N32 = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- N=8 instance ----------------
  logic           v8 = 1'b0;
  logic [N8-1:0]  a8 = '0;
  logic [N8-1:0]  b8 = '0;
  logic           i_ready8;
  logic           o_valid8;
  logic           o_ready8;
  logic [N8-1:0]  d8;
  logic           bw8;
  logic           ov8;
  logic           z8;

  logic rand_ordy = 1'b0;
  logic dir_ordy  = 1'b1;
  logic rnd_bit   = 1'b0;
  assign o_ready8 = rand_ordy ? rnd_bit : dir_ordy;

  always @(negedge clk) rnd_bit <= 1'($urandom_range(0, 1));

  serial_subtractor #(.N(N8)) dut8 (
    .clk(clk), .rst(rst_n),
    .i_valid(v8), .i_ready(i_ready8), .a(a8), .b(b8),
    .o_valid(o_valid8), .o_ready(o_ready8),
    .diff(d8), .borrow(bw8), .overflow(ov8), .zero(z8)
  );

  // Behavioural model: one transaction in flight, result visible N edges after accept
  bit            m_pending = 0;
  bit            m_valid   = 0;
  bit            m_ready   = 0;
  int            m_cnt     = 0;
  logic [N8-1:0] e_diff    = '0;
  logic          e_bw      = 1'b0;
  logic          e_ov      = 1'b0;
  logic          e_z       = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pending = 0;
      m_valid   = 0;
      m_ready   = 0;
      m_cnt     = 0;
    end else begin
      if (m_pending && m_valid && o_ready8) begin
        m_pending = 0;
      end else if (!m_pending && m_ready && v8) begin
        logic [N8:0] wide;
        wide      = {1'b0, a8} - {1'b0, b8};
        e_diff    = wide[N8-1:0];
        e_bw      = wide[N8];
        e_ov      = (a8[N8-1] != b8[N8-1]) && (e_diff[N8-1] != a8[N8-1]);
        e_z       = (e_diff == 0);
        m_pending = 1;
        m_cnt     = 0;
      end else if (m_pending && m_cnt < N8) begin
        m_cnt++;
      end
      m_valid = m_pending && (m_cnt == N8);
      m_ready = !m_pending;
    end
  end

  // Compare process: every falling edge, DUT outputs against the model
  always @(negedge clk) begin
    if (rst_n) begin
      chk("i_ready8", 64'(i_ready8), 64'(m_ready));
      chk("o_valid8", 64'(o_valid8), 64'(m_valid));
      if (m_valid) begin
        chk("diff8",     64'(d8),  64'(e_diff));
        chk("borrow8",   64'(bw8), 64'(e_bw));
        chk("overflow8", 64'(ov8), 64'(e_ov));
        chk("zero8",     64'(z8),  64'(e_z));
      end
    end else begin
      chk("rst_i_ready8", 64'(i_ready8), 64'd0);
      chk("rst_o_valid8", 64'(o_valid8), 64'd0);
      chk("rst_diff8",    64'({d8, bw8, ov8, z8}), 64'd0);
    end
  end

  // ---------------- N=32 instance ----------------
  logic           v32 = 1'b0;
  logic [N32-1:0] a32 = '0;
  logic [N32-1:0] b32 = '0;
  logic           i_ready32;
  logic           o_valid32;
  logic           o_ready32 = 1'b1;
  logic [N32-1:0] d32;
  logic           bw32;
  logic           ov32;
  logic           z32;

  serial_subtractor #(.N(N32)) dut32 (
    .clk(clk), .rst(rst_n),
    .i_valid(v32), .i_ready(i_ready32), .a(a32), .b(b32),
    .o_valid(o_valid32), .o_ready(o_ready32),
    .diff(d32), .borrow(bw32), .overflow(ov32), .zero(z32)
  );

  // ---------------- Directed tasks ----------------
  task automatic run8(input logic [7:0] ta, input logic [7:0] tb_, input logic [7:0] ed,
                      input logic eb, input logic eo, input logic ez,
                      input int hold, input bit noise);
    int n;
    rand_ordy = 1'b0;
    dir_ordy  = (hold == 0);
    @(negedge clk);
    a8 = ta; b8 = tb_; v8 = 1'b1;
    n = 0;
    while (!i_ready8 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait8", 64'(i_ready8), 64'd1);
    @(posedge clk);
    @(negedge clk);
    v8 = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (noise) begin
        v8 = 1'($urandom_range(0, 1));
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        chk("run_i_ready8", 64'(i_ready8), 64'd0);
      end
    end while (!o_valid8 && n < 100);
    v8 = 1'b0;
    chk("latency8", 64'(n), 64'(N8));
    chk("lit_diff8",     64'(d8),  64'(ed));
    chk("lit_borrow8",   64'(bw8), 64'(eb));
    chk("lit_overflow8", 64'(ov8), 64'(eo));
    chk("lit_zero8",     64'(z8),  64'(ez));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_diff8", 64'({d8, bw8, ov8, z8, o_valid8}), 64'({ed, eb, eo, ez, 1'b1}));
    end
    dir_ordy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("taken_o_valid8", 64'(o_valid8), 64'd0);
    chk("taken_i_ready8", 64'(i_ready8), 64'd1);
  endtask

  task automatic run32(input logic [31:0] ta, input logic [31:0] tb_, input logic [31:0] ed,
                       input logic eb, input logic eo, input logic ez);
    int n;
    logic [32:0] wide;
    @(negedge clk);
    a32 = ta; b32 = tb_; v32 = 1'b1;
    n = 0;
    while (!i_ready32 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait32", 64'(i_ready32), 64'd1);
    @(posedge clk);
    @(negedge clk);
    v32 = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!o_valid32 && n < 100);
    wide = {1'b0, ta} - {1'b0, tb_};
    chk("latency32",     64'(n),    64'(N32));
    chk("model_diff32",  64'(d32),  64'(wide[31:0]));
    chk("model_bw32",    64'(bw32), 64'(wide[32]));
    chk("lit_diff32",    64'(d32),  64'(ed));
    chk("lit_borrow32",  64'(bw32), 64'(eb));
    chk("lit_ovf32",     64'(ov32), 64'(eo));
    chk("lit_zero32",    64'(z32),  64'(ez));
    @(posedge clk);
    @(negedge clk);
    chk("taken_o_valid32", 64'(o_valid32), 64'd0);
  endtask

  // Watchdog so the run always terminates
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // ---------------- Main sequence ----------------
  initial begin
    int n;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs32", 64'({i_ready32, o_valid32, d32, bw32, ov32, z32}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("i_ready_before_edge8", 64'(i_ready8), 64'd0);
    @(posedge clk);
    #1;
    chk("i_ready_after_edge8", 64'(i_ready8), 64'd1);

    // Directed N=8 cases
    run8(8'd200, 8'd55,  8'd145,  1'b0, 1'b0, 1'b0, 0, 0);
    run8(8'd5,   8'd9,   8'hFC,   1'b1, 1'b0, 1'b0, 0, 0);
    run8(8'h80,  8'h01,  8'h7F,   1'b0, 1'b1, 1'b0, 0, 0);
    run8(8'h7F,  8'hFF,  8'h80,   1'b1, 1'b1, 1'b0, 0, 0);
    run8(8'h3C,  8'h3C,  8'h00,   1'b0, 1'b0, 1'b1, 0, 0);
    run8(8'd100, 8'd37,  8'd63,   1'b0, 1'b0, 1'b0, 5, 0);
    run8(8'd20,  8'd90,  8'd186,  1'b1, 1'b0, 1'b0, 0, 1);

    // Directed N=32 cases
    run32(32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 1'b1);
    run32(32'h0,        32'h1,        32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
    run32(32'h80000000, 32'h1,        32'h7FFFFFFF, 1'b0, 1'b1, 1'b0);

    // Randomized N=8 traffic with random output backpressure
    rand_ordy = 1'b1;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      if (t % 8 == 0) b8 = a8;
      v8 = 1'b1;
      n = 0;
      while (!i_ready8 && n < 300) begin
        @(negedge clk);
        n++;
      end
      chk("rand_accept8", 64'(i_ready8), 64'd1);
      @(posedge clk);
      @(negedge clk);
      v8 = 1'b0;
    end
    n = 0;
    while (m_pending && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("rand_drain8", 64'(m_pending), 64'd0);

    // Asynchronous reset in the middle of RUN, then a fresh transaction
    rand_ordy = 1'b0;
    dir_ordy  = 1'b1;
    @(negedge clk);
    a8 = 8'd77; b8 = 8'd20; v8 = 1'b1;
    n = 0;
    while (!i_ready8 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    v8 = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_outs8", 64'({i_ready8, o_valid8, d8, bw8, ov8, z8}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("no_result_after_rst8", 64'(o_valid8), 64'd0);
    run8(8'd10, 8'd3, 8'd7, 1'b0, 1'b0, 1'b0, 0, 0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor computing diff = a - b, LSB first, one bit per clock, using a single registered borrow.
- It is the sequential, inverse-operation counterpart to the team's combinational ripple-carry adder chain.
- Used where area matters more than latency, e.g. ALU fallback paths and comparators.
- Operands arrive on a valid/ready input handshake; results leave on a valid/ready output handshake.

Parameters:
- N, 32, operand/result width in bits; legal range N >= 2.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous and active-low (0 = reset).
- i_valid  input  1  operands a and b are valid.
- i_ready  output  1  block can accept operands.
- a  input  N  minuend, unsigned or two's complement.
- b  input  N  subtrahend.
- o_valid  output  1  result outputs are valid.
- o_ready  input  1  consumer accepts the result.
- diff  output  N  (a - b) mod 2^N.
- borrow  output  1  1 iff unsigned a < b.
- overflow  output  1  signed overflow: a[N-1] != b[N-1] and diff[N-1] != a[N-1].
- zero  output  1  1 iff diff == 0.

Behaviour:

Reset:
- While rst = 0, asynchronously: state = IDLE; i_ready = 0; o_valid = 0; diff = 0; borrow = 0; overflow = 0; zero = 0; internal shift registers, borrow register and bit counter cleared.
- The first cycle after rst deasserts, i_ready = 1.
- If reset asserts mid-RUN or mid-DONE, the operation is abandoned and no result is produced.

States:
- IDLE:
  - i_ready = 1, o_valid = 0.
  - On a rising edge with i_valid = 1: capture a and b into shift registers, set borrow register = 0, set counter = 0, go to RUN.
  - a and b are sampled only on this accept edge.
- RUN:
  - i_ready = 0, o_valid = 0. i_valid is ignored.
  - Each edge processes bit k = counter using the LSBs of the shift registers:
    - d = a_k ^ b_k ^ br
    - br_next = (~a_k & b_k) | (~(a_k ^ b_k) & br)
  - d is shifted into the MSB of the result register. The operand registers shift right. counter increments.
  - On the edge that processes bit N-1 (counter == N-1), go to DONE and register:
    - diff = result
    - borrow = br_next
    - overflow per the port definition
    - zero = (diff == 0)
- DONE:
  - o_valid = 1, i_ready = 0.
  - diff, borrow, overflow and zero are held stable while o_valid = 1 and o_ready = 0 (backpressure of any length).
  - On an edge with o_ready = 1: go to IDLE and clear o_valid.
  - Result outputs keep their last values after o_valid drops. They are meaningful only while o_valid = 1.

Timing:
- With the accept edge as E0, bits are processed on edges E1..EN, and o_valid rises after EN.
- Minimum accept-to-accept spacing is N+2 edges when o_ready is held at 1. No back-to-back overlap.
- o_ready asserted outside DONE has no effect.

Arithmetic:
- All arithmetic is modulo 2^N.
- borrow is the inverse of the carry out of a + ~b + 1.
- a == b gives diff = 0, borrow = 0, zero = 1, overflow = 0.

Test Plan:
- N=8, a=200, b=55, o_ready=1 -> o_valid rises exactly 8 edges after accept; diff=145, borrow=0, overflow=0, zero=0; i_ready=1 again 1 edge after the result is taken.
- N=8, a=5, b=9 -> diff=252 (0xFC), borrow=1, overflow=0, zero=0.
- N=8, a=0x80, b=0x01 -> diff=0x7F, borrow=0, overflow=1. Then a=0x7F, b=0xFF -> diff=0x80, borrow=1, overflow=1.
- N=32, a=b=0xDEADBEEF -> diff=0, zero=1, borrow=0. Then a=0, b=1 -> diff=0xFFFFFFFF, borrow=1.
- N=8, o_ready held 0 for 5 cycles in DONE -> o_valid and all result outputs stable the whole time. During RUN, toggle i_valid and change a/b -> result unaffected, i_ready=0 throughout.
- N=8, assert rst=0 at bit 4 of RUN, asynchronously between edges -> all outputs 0 immediately; after release, i_ready=1 and a new a=10, b=3 yields diff=7.
